// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module   : program_counter
// Purpose  : Holds the current instruction address. The next-PC value from
//            the upstream mux is captured on every falling clock edge so the
//            rising-edge fetch logic sees an address that is stable for the
//            whole high phase.
// Options  : PC_ALIGN_CHECK_EN - when defined, adds a registered 'misaligned'
//            flag and forces the stored address to word alignment.
// Revision : 1.0 - initial release
// ============================================================================
module program_counter #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc_in,
   output logic [WIDTH-1:0] pc_out
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic             misaligned
`endif
);

   // The initialiser gives a defined value before the first edge, so the
   // fetch address is never X even before reset is first sampled.
   logic [WIDTH-1:0] pc_q = RESET_VECTOR;
   logic [WIDTH-1:0] pc_d;

`ifdef PC_ALIGN_CHECK_EN
   logic misaligned_q = 1'b0;
   logic misaligned_d;

   // Next value: word-aligned address plus a flag for dropped low bits.
   always_comb begin
      pc_d         = {pc_in[WIDTH-1:2], 2'b00};
      misaligned_d = (pc_in[1:0] != 2'b00);
   end

   // Flag register shares the falling-edge timing and reset with pc_q.
   always_ff @(negedge clk) begin
      if (reset) begin
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= misaligned_d;
      end
   end

   assign misaligned = misaligned_q;
`else
   // Next value: the upstream address is taken verbatim, all bits kept.
   always_comb begin
      pc_d = pc_in;
   end
`endif

   // Falling-edge PC register; reset takes priority over the load.
   always_ff @(negedge clk) begin
      if (reset) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Output comes straight from the register; no path from pc_in.
   assign pc_out = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_counter
// Purpose  : Directed self-checking bench for program_counter.
// Options  : PC_ALIGN_CHECK_EN - selects the alignment-check expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_counter;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] pc_in;
   logic [WIDTH-1:0] pc_out;
`ifdef PC_ALIGN_CHECK_EN
   logic             misaligned;
`endif

   int checks = 0;
   int errors = 0;

   program_counter #(
      .WIDTH        (WIDTH),
      .RESET_VECTOR (32'h0000_0000)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .pc_in  (pc_in),
      .pc_out (pc_out)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .misaligned (misaligned)
`endif
   );

   // Clock starts low; first rising edge at 5, first falling edge at 10.
   always #5 clk = ~clk;

   // Power-up value, then reset held across two falling edges.
   task automatic test_reset();
      reset = 1'b1;
      pc_in = 32'h0000_0004;
      #1;
      checks++;
      if (pc_out !== 32'h0000_0000) begin
         errors++;
         $display("FAIL powerup_pc: got %h expected %h", pc_out, 32'h0000_0000);
      end
`ifdef PC_ALIGN_CHECK_EN
      checks++;
      if (misaligned !== 1'b0) begin
         errors++;
         $display("FAIL powerup_misaligned: got %b expected 0", misaligned);
      end
`endif
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (pc_out !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_hold_%0d: got %h expected %h", i, pc_out, 32'h0000_0000);
         end
         pc_in = 32'hDEAD_BEEC;
      end
   endtask

   // Release reset with clk low; rising edge must not load, falling edge must.
   task automatic test_load();
      reset = 1'b0;
      pc_in = 32'h0000_0004;
      @(posedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_0000) begin
         errors++;
         $display("FAIL load_after_rise: got %h expected %h", pc_out, 32'h0000_0000);
      end
      @(negedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_0004) begin
         errors++;
         $display("FAIL load_after_fall: got %h expected %h", pc_out, 32'h0000_0004);
      end
   endtask

   // pc_in changes during the high phase; output holds until the falling edge.
   task automatic test_hold_high();
      @(posedge clk);
      #1;
      pc_in = 32'h0000_0008;
      #1;
      checks++;
      if (pc_out !== 32'h0000_0004) begin
         errors++;
         $display("FAIL hold_high: got %h expected %h", pc_out, 32'h0000_0004);
      end
      @(negedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_0008) begin
         errors++;
         $display("FAIL load_8: got %h expected %h", pc_out, 32'h0000_0008);
      end
   endtask

   // Reset asserted mid-run for one falling edge, then released.
   task automatic test_reset_midrun();
      reset = 1'b1;
      pc_in = 32'h0000_000C;
      @(posedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_0008) begin
         errors++;
         $display("FAIL midrun_before_fall: got %h expected %h", pc_out, 32'h0000_0008);
      end
      @(negedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_0000) begin
         errors++;
         $display("FAIL midrun_reset: got %h expected %h", pc_out, 32'h0000_0000);
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_000C) begin
         errors++;
         $display("FAIL midrun_release: got %h expected %h", pc_out, 32'h0000_000C);
      end
   endtask

   // A new aligned address on every falling edge, including all-ones/wide patterns.
   task automatic test_back_to_back();
      logic [WIDTH-1:0] vec [4];
      vec[0] = 32'hFFFF_FFFC;
      vec[1] = 32'h1234_5678;
      vec[2] = 32'hA5A5_A5A4;
      vec[3] = 32'h8000_0000;
      for (int i = 0; i < 4; i++) begin
         pc_in = vec[i];
         @(negedge clk);
         #1;
         checks++;
         if (pc_out !== vec[i]) begin
            errors++;
            $display("FAIL b2b_%0d: got %h expected %h", i, pc_out, vec[i]);
         end
      end
   endtask

   // Addresses with nonzero low bits.
   task automatic test_unaligned();
`ifdef PC_ALIGN_CHECK_EN
      pc_in = 32'h0000_0006;
      @(negedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_0004) begin
         errors++;
         $display("FAIL align_pc_6: got %h expected %h", pc_out, 32'h0000_0004);
      end
      checks++;
      if (misaligned !== 1'b1) begin
         errors++;
         $display("FAIL align_flag_6: got %b expected 1", misaligned);
      end
      pc_in = 32'h0000_0010;
      @(negedge clk);
      #1;
      checks++;
      if (misaligned !== 1'b0) begin
         errors++;
         $display("FAIL align_flag_clear: got %b expected 0", misaligned);
      end
      pc_in = 32'h0000_0013;
      @(negedge clk);
      #1;
      checks++;
      if (misaligned !== 1'b1 || pc_out !== 32'h0000_0010) begin
         errors++;
         $display("FAIL align_13: got %h/%b expected %h/1", pc_out, misaligned, 32'h0000_0010);
      end
      reset = 1'b1;
      pc_in = 32'h0000_0007;
      @(negedge clk);
      #1;
      checks++;
      if (misaligned !== 1'b0 || pc_out !== 32'h0000_0000) begin
         errors++;
         $display("FAIL align_reset: got %h/%b expected %h/0", pc_out, misaligned, 32'h0000_0000);
      end
      reset = 1'b0;
`else
      pc_in = 32'h0000_0006;
      @(negedge clk);
      #1;
      checks++;
      if (pc_out !== 32'h0000_0006) begin
         errors++;
         $display("FAIL verbatim_6: got %h expected %h", pc_out, 32'h0000_0006);
      end
      pc_in = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      checks++;
      if (pc_out !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL verbatim_ones: got %h expected %h", pc_out, 32'hFFFF_FFFF);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_load();
      test_hold_high();
      test_reset_midrun();
      test_back_to_back();
      test_unaligned();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
